// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encoding and legal data widths.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_op_e;

    localparam int unsigned SHIFT_MIN_WIDTH = 8;
    localparam int unsigned SHIFT_MAX_WIDTH = 64;

    function automatic bit shift_width_legal(input int unsigned w);
        return (w >= SHIFT_MIN_WIDTH) && (w <= SHIFT_MAX_WIDTH) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered barrel-shifter stage: shifts by 2**K when shamt bit K is set.
// Rotate wrap logic exists only when SHIFT_UNIT_ROTATE_EN is defined; otherwise ROL acts as SLL.
module shift_stage
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int K     = 0,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt_in,
    input  logic [1:0]       op_in,
    input  logic             zero_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic [SHW-1:0]   shamt_out,
    output logic [1:0]       op_out,
    output logic             zero_out
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] shifted_next;
    logic             zero_next;
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic [SHW-1:0]   shamt_reg;
    logic [1:0]       op_reg;
    logic             zero_reg;

    always_comb begin
        shifted_next = data_in;
        if (shamt_in[K]) begin
            case (shift_op_e'(op_in))
                SHIFT_SRL: shifted_next = data_in >> S;
                SHIFT_SRA: shifted_next = WIDTH'($signed(data_in) >>> S);
`ifdef SHIFT_UNIT_ROTATE_EN
                SHIFT_SLL: shifted_next = data_in << S;
                SHIFT_ROL: shifted_next = {data_in[WIDTH-1-S:0], data_in[WIDTH-1:WIDTH-S]};
`else
                SHIFT_SLL,
                SHIFT_ROL: shifted_next = data_in << S;
`endif
                default:   shifted_next = data_in;
            endcase
        end
        // A zero operand stays zero under every op, so the flag only ever sets.
        zero_next = zero_in || (shifted_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            zero_reg  <= 1'b0;
        end else if (en) begin
            valid_reg <= valid_in;
            data_reg  <= shifted_next;
            zero_reg  <= zero_next;
        end
    end

    // Control fields are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            shamt_reg <= shamt_in;
            op_reg    <= op_in;
        end
    end

    assign valid_out = valid_reg;
    assign data_out  = data_reg;
    assign shamt_out = shamt_reg;
    assign op_out    = op_reg;
    assign zero_out  = zero_reg;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined shifter (SLL/SRL/SRA/ROL), one stage per shift-amount bit, valid/ready handshake.
// Optional rotate support via macro SHIFT_UNIT_ROTATE_EN (see shift_stage).
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    if (!shift_width_legal(WIDTH)) begin : g_bad_width
        $error("shift_unit_pipe: WIDTH must be a power of two in 8..64");
    end

    logic             stall;
    logic             stage_en;
    logic             valid_w [0:SHW];
    logic [WIDTH-1:0] data_w  [0:SHW];
    logic [SHW-1:0]   shamt_w [0:SHW];
    logic [1:0]       op_w    [0:SHW];
    logic             zero_w  [0:SHW];

    // The whole pipe freezes together; bubbles simply flow when not stalled.
    assign stall    = out_valid && !out_ready;
    assign stage_en = !stall;
    assign in_ready = !rst && !stall;

    assign valid_w[0] = in_valid && in_ready;
    assign data_w[0]  = in_data;
    assign shamt_w[0] = in_shamt;
    assign op_w[0]    = in_op;
    assign zero_w[0]  = (in_data == '0);

    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (gi)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (stage_en),
            .valid_in  (valid_w[gi]),
            .data_in   (data_w[gi]),
            .shamt_in  (shamt_w[gi]),
            .op_in     (op_w[gi]),
            .zero_in   (zero_w[gi]),
            .valid_out (valid_w[gi+1]),
            .data_out  (data_w[gi+1]),
            .shamt_out (shamt_w[gi+1]),
            .op_out    (op_w[gi+1]),
            .zero_out  (zero_w[gi+1])
        );
    end

    assign out_valid = valid_w[SHW];
    assign out_data  = data_w[SHW];
    assign out_zero  = zero_w[SHW];

endmodule
